// File: rtl/fifo_axis_packetizer.sv
// Read stage for a FWFT FIFO: pops words into a 2-entry skid buffer and drives them
// as an AXI-Stream master with tlast inserted every pkt_len beats.
module fifo_axis_packetizer #(
  parameter int DATA_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] fifo_dout,
  input  logic                  fifo_empty,
  output logic                  fifo_rd_en,
  input  logic [LEN_WIDTH-1:0]  pkt_len,
  output logic [DATA_WIDTH-1:0] m_axis_tdata,
  output logic                  m_axis_tvalid,
  input  logic                  m_axis_tready,
  output logic                  m_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count
);

  logic [1:0]            occ;
  logic [1:0]            occ_next;
  logic [DATA_WIDTH-1:0] head_data;
  logic                  head_last;
  logic [DATA_WIDTH-1:0] tail_data;
  logic                  tail_last;
  logic                  valid_q;
  logic [LEN_WIDTH-1:0]  beat_cnt;
  logic [LEN_WIDTH-1:0]  len_q;
  logic [LEN_WIDTH-1:0]  len_eff;
  logic                  push_last;
  logic                  rd;
  logic                  pop;

  // Read decision uses only registered occupancy, keeping tready off the rd_en path.
  assign rd            = !rst && !fifo_empty && (occ != 2'd2);
  assign pop           = valid_q && m_axis_tready;
  assign fifo_rd_en    = rd;
  assign m_axis_tvalid = valid_q;
  assign m_axis_tdata  = head_data;
  assign m_axis_tlast  = head_last;

  always_comb begin
    occ_next  = occ + {1'b0, rd} - {1'b0, pop};
    len_eff   = len_q;
    if (beat_cnt == '0) begin
      len_eff = (pkt_len == '0) ? LEN_WIDTH'(1) : pkt_len;
    end
    push_last = (beat_cnt == (len_eff - LEN_WIDTH'(1)));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      occ       <= 2'd0;
      valid_q   <= 1'b0;
      head_data <= '0;
      head_last <= 1'b0;
      tail_data <= '0;
      tail_last <= 1'b0;
      beat_cnt  <= '0;
      len_q     <= '0;
      pkt_count <= '0;
    end else begin
      occ     <= occ_next;
      valid_q <= (occ_next != 2'd0);

      if (rd && ((occ == 2'd0) || ((occ == 2'd1) && pop))) begin
        head_data <= fifo_dout;
        head_last <= push_last;
      end else if (rd && (occ == 2'd1)) begin
        tail_data <= fifo_dout;
        tail_last <= push_last;
      end else if (pop && (occ == 2'd2)) begin
        head_data <= tail_data;
        head_last <= tail_last;
      end

      // Packet boundaries are decided when a word enters the buffer.
      if (rd) begin
        if (beat_cnt == '0) begin
          len_q <= len_eff;
        end
        beat_cnt <= push_last ? '0 : beat_cnt + LEN_WIDTH'(1);
      end

      if (pop && head_last) begin
        pkt_count <= pkt_count + CNT_WIDTH'(1);
      end
    end
  end

endmodule

// File: tb/tb_fifo_axis_packetizer.sv
// Self-checking bench: a queue-based FIFO and packet model predict every stream beat,
// with a second instance (CNT_WIDTH=2) checking packet counter wrap.
module tb_fifo_axis_packetizer;

  typedef struct {
    logic [7:0] data;
    logic       last;
  } beat_t;

  logic        clk;
  logic        rst;
  logic [7:0]  fifo_dout;
  logic        fifo_empty;
  logic        fifo_rd_en;
  logic [7:0]  pkt_len;
  logic [7:0]  m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic [15:0] pkt_count;

  logic        rd2;
  logic [7:0]  tdata2;
  logic        tvalid2;
  logic        tlast2;
  logic [1:0]  pkt_count2;

  logic [7:0]  q[$];
  beat_t       exp_q[$];
  int          model_cnt;
  int          m_pos;
  int          m_len;
  int          reads;
  int          dut_reads;
  int          beat_idx;
  logic [31:0] last_mask;
  bit          last_hs;
  int          cyc;
  int          hs_first;
  int          hs_last;
  int          hs_cnt;
  int          total;
  int          passed;

  fifo_axis_packetizer #(.DATA_WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(fifo_rd_en), .pkt_len(pkt_len), .m_axis_tdata(m_axis_tdata),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(m_axis_tlast), .pkt_count(pkt_count)
  );

  fifo_axis_packetizer #(.DATA_WIDTH(8), .LEN_WIDTH(8), .CNT_WIDTH(2)) dut2 (
    .clk(clk), .rst(rst), .fifo_dout(fifo_dout), .fifo_empty(fifo_empty),
    .fifo_rd_en(rd2), .pkt_len(pkt_len), .m_axis_tdata(tdata2),
    .m_axis_tvalid(tvalid2), .m_axis_tready(m_axis_tready),
    .m_axis_tlast(tlast2), .pkt_count(pkt_count2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock of stimulus: drive at negedge, check, then advance the model at posedge.
  task automatic cycle(input bit tr, input bit gap);
    bit    exp_rd;
    bit    exp_valid;
    bit    tl_s;
    beat_t b;
    m_axis_tready = tr;
    fifo_empty    = gap || (q.size() == 0);
    fifo_dout     = (q.size() != 0) ? q[0] : 8'h00;
    #1;
    exp_rd    = !fifo_empty && (exp_q.size() < 2);
    exp_valid = (exp_q.size() != 0);
    total++;
    if (fifo_rd_en !== exp_rd)
      $display("[TB] FAIL rd_en cyc=%0d got=%b exp=%b", cyc, fifo_rd_en, exp_rd);
    else passed++;
    total++;
    if (m_axis_tvalid !== exp_valid)
      $display("[TB] FAIL tvalid cyc=%0d got=%b exp=%b", cyc, m_axis_tvalid, exp_valid);
    else passed++;
    if (exp_valid) begin
      total++;
      if (m_axis_tdata !== exp_q[0].data || m_axis_tlast !== exp_q[0].last)
        $display("[TB] FAIL beat cyc=%0d got=%h/%b exp=%h/%b", cyc, m_axis_tdata,
                 m_axis_tlast, exp_q[0].data, exp_q[0].last);
      else passed++;
    end
    total++;
    if (pkt_count !== 16'(model_cnt))
      $display("[TB] FAIL pkt_count cyc=%0d got=%0d exp=%0d", cyc, pkt_count, model_cnt);
    else passed++;
    total++;
    if (pkt_count2 !== 2'(model_cnt % 4) || rd2 !== exp_rd)
      $display("[TB] FAIL narrow_inst cyc=%0d got=%0d/%b exp=%0d/%b", cyc, pkt_count2, rd2,
               model_cnt % 4, exp_rd);
    else passed++;
    tl_s = m_axis_tlast;
    if (fifo_rd_en) dut_reads++;
    @(posedge clk);
    cyc++;
    last_hs = 1'b0;
    if (exp_valid && tr) begin
      b = exp_q.pop_front();
      if (b.last) model_cnt++;
      if (tl_s && beat_idx < 32) last_mask[beat_idx] = 1'b1;
      beat_idx++;
      if (hs_cnt == 0) hs_first = cyc;
      hs_last = cyc;
      hs_cnt++;
      last_hs = 1'b1;
    end
    if (exp_rd) begin
      b.data = q.pop_front();
      if (m_pos == 0) m_len = (pkt_len == 0) ? 1 : int'(pkt_len);
      m_pos++;
      b.last = (m_pos == m_len);
      if (b.last) m_pos = 0;
      exp_q.push_back(b);
      reads++;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    m_axis_tready = 1'b0;
    fifo_empty = (q.size() == 0);
    fifo_dout  = (q.size() != 0) ? q[0] : 8'h00;
    #1;
    total++;
    if (fifo_rd_en !== 1'b0) $display("[TB] FAIL rd_in_reset got=%b exp=0", fifo_rd_en);
    else passed++;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    model_cnt = 0;
    m_pos = 0;
    m_len = 0;
    reads = 0;
    dut_reads = 0;
    beat_idx = 0;
    last_mask = '0;
    hs_cnt = 0;
  endtask

  task automatic drain(input int budget, input bit random_mode);
    int n;
    n = 0;
    while ((q.size() != 0 || exp_q.size() != 0) && n < budget) begin
      if (random_mode) cycle(1'($urandom_range(0, 1)), ($urandom_range(0, 3) == 0));
      else cycle(1'b1, 1'b0);
      n++;
    end
    if (q.size() != 0 || exp_q.size() != 0) begin
      total++;
      $display("[TB] FAIL drain_timeout left=%0d/%0d exp=0/0", q.size(), exp_q.size());
    end
  endtask

  task automatic load(input int first, input int n);
    for (int i = 0; i < n; i++) q.push_back(8'(first + i));
  endtask

  task automatic test_reset();
    do_reset();
    total++;
    if (m_axis_tvalid !== 1'b0 || m_axis_tdata !== 8'h00 || m_axis_tlast !== 1'b0 ||
        pkt_count !== 16'd0)
      $display("[TB] FAIL reset_outputs got=%b/%h/%b/%0d exp=0/00/0/0", m_axis_tvalid,
               m_axis_tdata, m_axis_tlast, pkt_count);
    else passed++;
    cycle(1'b1, 1'b0);
  endtask

  task automatic test_basic();
    do_reset();
    pkt_len = 8'd4;
    load(1, 8);
    drain(40, 1'b0);
    total++;
    if (hs_cnt != 8 || (hs_last - hs_first) != 7)
      $display("[TB] FAIL basic_throughput got=%0d beats in %0d cycles exp=8 in 7",
               hs_cnt, hs_last - hs_first);
    else passed++;
    total++;
    if (last_mask !== 32'h88 || pkt_count !== 16'd2)
      $display("[TB] FAIL basic_last got=%h/%0d exp=88/2", last_mask, pkt_count);
    else passed++;
  endtask

  task automatic test_backpressure();
    do_reset();
    pkt_len = 8'd4;
    load(1, 8);
    for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0);
    total++;
    if (dut_reads != 2 || m_axis_tdata !== 8'h01)
      $display("[TB] FAIL backpressure got=%0d reads/%h exp=2/01", dut_reads, m_axis_tdata);
    else passed++;
    drain(40, 1'b0);
    total++;
    if (pkt_count !== 16'd2) $display("[TB] FAIL bp_count got=%0d exp=2", pkt_count);
    else passed++;
  endtask

  task automatic test_random();
    do_reset();
    pkt_len = 8'd7;
    for (int i = 0; i < 1000; i++) q.push_back(8'($urandom_range(0, 255)));
    drain(8000, 1'b1);
    total++;
    if (pkt_count !== 16'd142 || hs_cnt != 1000)
      $display("[TB] FAIL random_count got=%0d/%0d exp=142/1000", pkt_count, hs_cnt);
    else passed++;
  endtask

  task automatic test_len_edge();
    do_reset();
    pkt_len = 8'd0;
    load(8'h20, 4);
    drain(40, 1'b0);
    total++;
    if (last_mask !== 32'hF || pkt_count !== 16'd4)
      $display("[TB] FAIL len0 got=%h/%0d exp=f/4", last_mask, pkt_count);
    else passed++;
    pkt_len = 8'd1;
    load(8'h30, 3);
    drain(40, 1'b0);
    total++;
    if (last_mask !== 32'h7F || pkt_count !== 16'd7)
      $display("[TB] FAIL len1 got=%h/%0d exp=7f/7", last_mask, pkt_count);
    else passed++;
    do_reset();
    pkt_len = 8'd3;
    load(8'h40, 8);
    for (int n = 0; n < 40 && (q.size() != 0 || exp_q.size() != 0); n++) begin
      if (reads == 2) pkt_len = 8'd5;
      cycle(1'b1, 1'b0);
    end
    total++;
    if (last_mask !== 32'h84 || pkt_count !== 16'd2)
      $display("[TB] FAIL len_change got=%h/%0d exp=84/2", last_mask, pkt_count);
    else passed++;
  endtask

  task automatic test_wrap();
    int seq[5];
    int k;
    seq = '{1, 2, 3, 0, 1};
    k = 0;
    do_reset();
    pkt_len = 8'd1;
    load(8'h50, 5);
    for (int n = 0; n < 30 && (q.size() != 0 || exp_q.size() != 0); n++) begin
      cycle(1'b1, 1'b0);
      if (last_hs && k < 5) begin
        #1;
        total++;
        if (pkt_count2 !== 2'(seq[k]))
          $display("[TB] FAIL wrap[%0d] got=%0d exp=%0d", k, pkt_count2, seq[k]);
        else passed++;
        k++;
      end
    end
    total++;
    if (k != 5) $display("[TB] FAIL wrap_beats got=%0d exp=5", k);
    else passed++;
  endtask

  task automatic test_mid_reset();
    do_reset();
    pkt_len = 8'd4;
    load(8'h60, 10);
    for (int i = 0; i < 3; i++) cycle(1'b0, 1'b0);
    do_reset();
    total++;
    if (m_axis_tvalid !== 1'b0 || pkt_count !== 16'd0)
      $display("[TB] FAIL mid_reset got=%b/%0d exp=0/0", m_axis_tvalid, pkt_count);
    else passed++;
    drain(40, 1'b0);
    total++;
    if (last_mask !== 32'h88 || hs_cnt != 8)
      $display("[TB] FAIL mid_reset_pkt got=%h/%0d exp=88/8", last_mask, hs_cnt);
    else passed++;
  endtask

  initial begin
    total = 0;
    passed = 0;
    cyc = 0;
    rst = 1'b1;
    pkt_len = 8'd4;
    m_axis_tready = 1'b0;
    fifo_empty = 1'b1;
    fifo_dout = 8'h00;
    @(negedge clk);
    test_reset();
    test_basic();
    test_backpressure();
    test_random();
    test_len_edge();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/fifo_axis_packetizer.md
Name: fifo_axis_packetizer

Overview:
Downstream read stage for the first-word-fall-through FIFO. Pops words from the FIFO read port and drives them as an AXI-Stream master. Inserts tlast every pkt_len beats and counts completed packets. A 2-entry output skid buffer breaks the m_axis_tready -> fifo_rd_en combinational path while keeping 1 beat/cycle throughput.

Parameters:
DATA_WIDTH, 8, width of FIFO word and m_axis_tdata
LEN_WIDTH, 8, width of pkt_len input and internal beat counter
CNT_WIDTH, 16, width of pkt_count output

Ports:
clk  input  1  single clock, all logic on posedge
rst  input  1  synchronous, active-high reset
fifo_dout  input  DATA_WIDTH  FIFO head word, valid whenever fifo_empty=0 (FWFT)
fifo_empty  input  1  FIFO empty flag
fifo_rd_en  output  1  pop FIFO head this cycle
pkt_len  input  LEN_WIDTH  beats per packet; sampled at the first beat of each packet
m_axis_tdata  output  DATA_WIDTH  stream data
m_axis_tvalid  output  1  stream valid
m_axis_tready  input  1  stream ready
m_axis_tlast  output  1  last beat of packet
pkt_count  output  CNT_WIDTH  packets fully transferred (tlast handshakes), wraps modulo 2**CNT_WIDTH

Behaviour:
- Clock and reset: one clock (clk); reset (rst) is synchronous and active-high.
- Reset values: fifo_rd_en=0, m_axis_tvalid=0, m_axis_tdata=0, m_axis_tlast=0, pkt_count=0, buffer occupancy=0, beat counter=0, latched length=0. Reset mid-packet discards buffered beats and the partial count. The next beat read starts a new packet.
- Buffer: 2 entries {data, last}, occupancy occ in 0..2. Head entry drives tdata/tlast. m_axis_tvalid = (occ!=0), registered.
- Read rule: fifo_rd_en = !rst && !fifo_empty && (occ<2). It depends on registered state and fifo_empty only, never on m_axis_tready. A popped word is fifo_dout sampled on that same clock edge (FWFT, zero latency).
- Handshake: pop out when tvalid && tready. Occupancy update: occ_next = occ + rd - pop.
- Push while occ=0, or occ=1 with a simultaneous pop: the word becomes the head.
- Push while occ=1 with no pop: the word goes to the second entry.
- Pop while occ=2: the second entry shifts to the head.
- Data is never reordered, dropped or duplicated.
- AXI rule: once tvalid=1, tdata/tlast stay stable until the handshake.
- Latency: fifo_rd_en at edge N gives tvalid=1 with that word after edge N, i.e. 1 cycle. Sustained throughput is 1 beat/cycle when tready=1 and the FIFO is non-empty.
- Packetizer, counted at push time:
  - beat_cnt (LEN_WIDTH) counts beats pushed in the current packet.
  - On a push with beat_cnt=0, latch len = (pkt_len==0 ? 1 : pkt_len).
  - The pushed entry's last bit = (beat_cnt == len_eff-1), where len_eff is the just-latched value for the first beat.
  - On last, beat_cnt returns to 0; otherwise it increments.
  - pkt_len changes mid-packet have no effect until the next packet.
  - pkt_len=1 or 0: every beat is last.
  - Maximum packet length is 2**LEN_WIDTH-1.
- pkt_count increments by 1 on each tvalid && tready && tlast and wraps to 0 after all-ones.
- tready held low: the buffer fills to 2, then fifo_rd_en=0. No FIFO reads occur until a pop.
- FIFO empty with tready=1: tvalid drops once the buffer drains. There are no bubbles in data content, only gaps in valid.

Test Plan:
- Reset, then FIFO preloaded with 0x01..0x08, pkt_len=4, tready=1 -> beats 0x01..0x08 on consecutive cycles, tlast on 0x04 and 0x08, pkt_count=2, fifo_rd_en never high while fifo_empty=1.
- Same data, tready=0 for 5 cycles after the first read -> exactly 2 words read and then fifo_rd_en=0. tdata=0x01 stable while tvalid=1. On tready=1, order 0x01..0x08 is preserved.
- Random tready (50%) and random fifo_empty gaps, 1000 words, pkt_len=7 -> scoreboard matches in order, tlast on every 7th beat, pkt_count=floor(1000/7)=142.
- pkt_len=0 and pkt_len=1 -> tlast on every beat. pkt_len changed 3->5 after the 2nd beat -> first packet still 3 beats, next packet 5.
- CNT_WIDTH=2, pkt_len=1, 5 beats -> pkt_count sequence 1,2,3,0,1.
- rst asserted for 1 cycle with occ=2 mid-packet -> next cycle tvalid=0, pkt_count=0. The subsequent pkt_len=4 stream gets tlast on its 4th beat.
